// File: rtl/key_sched_pkg.sv
// Shared DES key-schedule tables, state encoding and bit-level helpers.
// DES numbering is MSB-first: DES bit n of a W-bit vector lives at index W-n.
package key_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Rotation applied before subkey Kn (index n-1).
  localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int j = 1; j <= 56; j++) cd[56-j] = key[64-PC1_TAB[j-1]];
    return cd;
  endfunction

  // C and D halves rotate independently; two selects a double rotation.
  function automatic logic [55:0] rotl(input logic [55:0] cd, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[25:0], c[27:26], d[25:0], d[27:26]};
    return {c[26:0], c[27], d[26:0], d[27]};
  endfunction

  function automatic logic [55:0] rotr(input logic [55:0] cd, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[1:0], c[27:2], d[1:0], d[27:2]};
    return {c[0], c[27:1], d[0], d[27:1]};
  endfunction

  // DES keys carry odd parity per byte; any even byte is a violation.
  function automatic logic key_parity_err(input logic [63:0] key);
    logic err;
    err = 1'b0;
    for (int b = 0; b < 8; b++) if (!(^key[8*b +: 8])) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/key_pc2.sv
// PC-2 permuted choice: 56-bit C/D register contents to 48-bit round subkey.
module key_pc2
  import key_sched_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 1; i <= 48; i++) subkey[48-i] = cd[56-PC2_TAB[i-1]];
  end

endmodule

// File: rtl/key_schedule.sv
// DES key schedule: emits 16 subkeys over a valid/ready stream, forward for
// encryption or reversed for decryption, with optional key parity flag.
module key_schedule
  import key_sched_pkg::*;
#(
  parameter int PARITY_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        last,
  output logic        parity_err,
  output logic        state_dbg
);

  state_t      state, state_nxt;
  logic [55:0] cd;
  logic        dec_q;
  logic [3:0]  cnt;
  logic        par_q;
  logic        xfer;
  logic [3:0]  shift_idx;
  logic        shift_two;

  // Handshake: subkey/round/last are valid while subkey_valid is high and are
  // held unchanged until a cycle with subkey_valid & subkey_ready (a transfer);
  // each transfer steps C/D, and the transfer carrying last ends the schedule.
  assign xfer = (state == RUN) && subkey_ready;

  // Encrypt walks forward to the next round's left shift; decrypt undoes the
  // shift of the round just emitted.
  assign shift_idx = dec_q ? (4'd15 - cnt) : (cnt + 4'd1);
  assign shift_two = (SHIFT_TAB[shift_idx] == 2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (xfer && cnt == 4'd15) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cd    <= '0;
      dec_q <= 1'b0;
      cnt   <= '0;
      par_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        cd    <= decrypt ? pc1(key) : rotl(pc1(key), SHIFT_TAB[0] == 2);
        dec_q <= decrypt;
        cnt   <= '0;
        par_q <= key_parity_err(key);
      end else if (xfer) begin
        cd <= dec_q ? rotr(cd, shift_two) : rotl(cd, shift_two);
        if (cnt != 4'd15) cnt <= cnt + 4'd1;
      end
    end
  end

  key_pc2 u_pc2 (
    .cd     (cd),
    .subkey (subkey)
  );

  assign busy         = (state == RUN);
  assign subkey_valid = (state == RUN);
  assign state_dbg    = state;
  assign round        = dec_q ? (4'd15 - cnt) : cnt;
  assign last         = (state == RUN) && (cnt == 4'd15);
  assign parity_err   = (PARITY_CHECK != 0) ? par_q : 1'b0;

endmodule

// File: tb/tb_key_schedule.sv
// Scoreboard bench for key_schedule: a table-driven DES key-schedule model
// feeds an expected queue that a negedge monitor drains on every transfer.
module tb_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] key = '0;
  logic        subkey_ready = 1'b0;

  logic        busy, subkey_valid, last, parity_err, state_dbg;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        busy_np, subkey_valid_np, last_np, parity_err_np, state_dbg_np;
  logic [47:0] subkey_np;
  logic [3:0]  round_np;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  bit rand_ready = 1'b0;

  logic [52:0] exp_q[$];
  logic [47:0] mk[16];

  int pc1_t[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int sh_t[16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  key_schedule #(.PARITY_CHECK(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .round(round), .last(last), .parity_err(parity_err),
    .state_dbg(state_dbg)
  );

  key_schedule #(.PARITY_CHECK(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .busy(busy_np), .subkey_valid(subkey_valid_np), .subkey_ready(subkey_ready),
    .subkey(subkey_np), .round(round_np), .last(last_np), .parity_err(parity_err_np),
    .state_dbg(state_dbg_np)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Kr = PC-2 of (C0,D0) each rotated left by the cumulative shift count.
  function automatic void model(input logic [63:0] k);
    logic cd0 [1:56];
    logic cdn [1:56];
    int   tot;
    tot = 0;
    for (int n = 1; n <= 56; n++) cd0[n] = k[64 - pc1_t[n-1]];
    for (int r = 0; r < 16; r++) begin
      tot += sh_t[r];
      for (int j = 1; j <= 28; j++) begin
        cdn[j]      = cd0[((j - 1 + tot) % 28) + 1];
        cdn[28 + j] = cd0[28 + ((j - 1 + tot) % 28) + 1];
      end
      for (int i = 1; i <= 48; i++) mk[r][48 - i] = cdn[pc2_t[i-1]];
    end
  endfunction

  function automatic logic model_par(input logic [63:0] k);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) e = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_sched(input logic [63:0] k, input logic dec);
    int r;
    model(k);
    for (int n = 0; n < 16; n++) begin
      r = dec ? 15 - n : n;
      exp_q.push_back({4'(r), (n == 15), mk[r]});
    end
  endtask

  task automatic do_start(input logic [63:0] k, input logic dec);
    @(posedge clk); #1;
    key = k;
    decrypt = dec;
    start = 1'b1;
    push_sched(k, dec);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("valid_after_start", subkey_valid, 1);
    check("busy_after_start", busy, 1);
    check("parity_err", parity_err, model_par(k));
    check("parity_err_nocheck", parity_err_np, 0);
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || busy) && b < 400) begin
      @(negedge clk);
      b++;
    end
    n_vec++;
    if (b >= 400) begin
      n_err++;
      $display("FAIL sched_timeout: %0d subkeys outstanding, busy=%0b", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  function automatic logic [63:0] rand_key(input bit fix_parity);
    logic [63:0] k;
    k = {$urandom, $urandom};
    if (fix_parity)
      for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) k[8*b] = ~k[8*b];
    return k;
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) subkey_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [52:0] held;
  bit          held_v = 1'b0;
  logic [52:0] exp_item;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("stall_hold", {round, last, subkey}, held);
      if (subkey_valid && subkey_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_subkey: got %0h round %0d, expected none", subkey, round);
        end else begin
          exp_item = exp_q.pop_front();
          check("subkey_xfer", {round, last, subkey}, exp_item);
        end
        n_pop++;
        held_v = 1'b0;
      end else if (subkey_valid) begin
        held   = {round, last, subkey};
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] k;
    int base;
    int b;

    #3;
    check("rst_valid", subkey_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_subkey", subkey, 0);
    check("rst_round", round, 0);
    check("rst_last", last, 0);
    check("rst_parity", parity_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    subkey_ready = 1'b1;

    // Reference vector, both directions, continuous ready.
    do_start(64'h133457799BBCDFF1, 1'b0);
    check("known_enc_first", subkey, 48'h1B02EFFC7072);
    check("known_enc_round", round, 0);
    wait_done();
    do_start(64'h133457799BBCDFF1, 1'b1);
    check("known_dec_first", subkey, 48'hCB3D8B0E17F5);
    check("known_dec_round", round, 15);
    wait_done();

    // Random keys and modes with random back-pressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      do_start(rand_key($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
      wait_done();
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    subkey_ready = 1'b1;

    // All-zero key: parity violation flagged, schedule still runs to the end.
    do_start(64'h0, 1'b0);
    wait_done();
    check("zero_key_parity_hold", parity_err, 1);
    check("zero_key_parity_nocheck", parity_err_np, 0);

    // start, key and decrypt disturbed mid-schedule must be ignored.
    rand_ready = 1'b1;
    k = rand_key(1'b1);
    do_start(k, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    key = ~k;
    decrypt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key = rand_key(1'b0);
    @(negedge clk);
    check("busy_after_midstart", busy, 1);
    wait_done();
    check("parity_after_midstart", parity_err, model_par(k));
    rand_ready = 1'b0;
    @(posedge clk); #1;
    subkey_ready = 1'b1;

    // Asynchronous reset after the 5th transfer aborts the schedule.
    base = n_pop;
    do_start(64'h0, 1'b1);
    b = 0;
    while (n_pop - base < 5 && b < 100) begin
      @(negedge clk);
      b++;
    end
    n_vec++;
    if (b >= 100) begin
      n_err++;
      $display("FAIL reset_setup_timeout: %0d transfers, expected 5", n_pop - base);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", subkey_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_subkey", subkey, 0);
    check("abort_round", round, 0);
    check("abort_last", last, 0);
    check("abort_parity", parity_err, 0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_reset_idle_valid", subkey_valid, 0);
      check("post_reset_idle_busy", busy, 0);
    end

    // Normal operation resumes after the abort.
    do_start(64'h133457799BBCDFF1, 1'b0);
    check("resume_first", subkey, 48'h1B02EFFC7072);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 Parameter: PARITY_CHECK, default 1, enables the DES odd-parity check on the loaded key.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a new 16-subkey schedule; sampled only in IDLE.
REQ-005 decrypt  input  1  mode, sampled with start: 0 emits K1..K16, 1 emits K16..K1.
REQ-006 key  input  64 [64:1]  DES key; key[n] is DES bit n (key[1] = MSB of hex string).
REQ-007 busy  output  1  high while a schedule is in progress.
REQ-008 subkey_valid  output  1  subkey, round and last are valid.
REQ-009 subkey_ready  input  1  consumer accepts the current subkey when high with subkey_valid.
REQ-010 subkey  output  48 [48:1]  PC-2 result; subkey[n] is DES subkey bit n.
REQ-011 round  output  4  DES round index 0..15 of the presented subkey (Kn -> n-1).
REQ-012 last  output  1  high with the 16th subkey of the schedule.
REQ-013 parity_err  output  1  key parity violation flag for the current/most recent schedule.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN; busy = (state == RUN).
REQ-015 In IDLE, start=1 SHALL: load C/D (28 bits each) from PC-1(key), latch decrypt, clear the emit counter, and enter RUN.
REQ-016 In encrypt mode, the load SHALL include the round-1 left rotation (C1/D1); in decrypt mode, C/D SHALL load unrotated (C0/D0 = C16/D16).
REQ-017 subkey_valid SHALL rise exactly one cycle after the start cycle and stay high through all 16 subkeys while ready permits.
REQ-018 Encrypt left-rotation amounts before each subsequent subkey SHALL be 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 Decrypt right-rotation amounts before each subsequent subkey SHALL be 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-020 subkey SHALL equal PC-2(C,D) of the current registers; it is a registered-state path with no input-to-output combinational path.
REQ-021 When subkey_valid=1 and subkey_ready=0, subkey, round and last SHALL hold stable.
REQ-022 A transfer (valid & ready) SHALL advance C/D by one schedule step; one subkey per cycle is allowed under continuous ready.
REQ-023 round SHALL be 0..15 in encrypt mode and 15..0 in decrypt mode; last SHALL be high on the 16th emitted subkey.
REQ-024 A transfer with last=1 SHALL return the FSM to IDLE and drive subkey_valid low on the next cycle.
REQ-025 start asserted in RUN, and changes on key or decrypt during RUN, SHALL be ignored.
REQ-026 With PARITY_CHECK=1, parity_err SHALL be registered at start: 1 if any byte key[8k:8k-7] has an even number of ones.
REQ-027 The schedule SHALL proceed regardless of the parity result, and parity_err SHALL hold until the next accepted start.
REQ-028 With PARITY_CHECK=0, parity_err SHALL be constant 0.

Reset
REQ-029 rst_n low SHALL immediately force: IDLE, busy=0, subkey_valid=0, subkey=0, round=0, last=0, parity_err=0, and C/D=0.
REQ-030 Reset asserted mid-schedule SHALL abort the schedule; after release, no subkey SHALL appear until a new start.

Structure
REQ-031 PC-1 and PC-2 index tables, the 16-entry shift schedule, and the state encoding SHALL live in a shared package, key_sched_pkg.
REQ-032 PC-2 SHALL be a combinational sub-module, key_pc2 (56-bit C/D in, 48-bit subkey out); the rotation/FSM logic SHALL remain in key_schedule.

Verification
REQ-033 key=0x133457799BBCDFF1, decrypt=0, ready=1 -> first subkey 0x1B02EFFC7072 (round 0) one cycle after start; 16th is 0xCB3D8B0E17F5 (round 15, last=1); parity_err=0.
REQ-034 Same key, decrypt=1 -> first subkey 0xCB3D8B0E17F5 (round 15); 16th is 0x1B02EFFC7072 (round 0, last=1).
REQ-035 Random ready deassertion during a schedule -> subkey, round and last stable while stalled; exactly 16 transfers occur, in order, matching a reference model.
REQ-036 key=0x0000000000000000 with PARITY_CHECK=1 -> parity_err=1 and the full 16-subkey schedule still completes; with PARITY_CHECK=0 -> parity_err=0.
REQ-037 start pulsed and key changed mid-schedule -> no restart and subkeys unaffected; rst_n pulsed after the 5th transfer -> all outputs 0 immediately, and no valid until the next start.
